miner_lane_dispatcher: RTL and testbench
========================================

Name: miner_lane_dispatcher

Overview:
Parametrised successor to the single-core miner control path. It schedules nonces across NUM_LANES external double-SHA256 lanes, collects their digests and compares each against a 256-bit target. It reports the first winning nonce, or exhaustion of the requested range. It sits between the host/UART message layer and the array of sha256-based hash lanes, which receive blk1/blk2 directly.

Parameters:
NUM_LANES, 4, number of parallel hash lanes (1..16)
NONCE_W, 32, nonce width in bits
DIGEST_W, 256, digest/target width in bits

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; high = mine, low = stop after current round
nonce_start  in  NONCE_W  first nonce of range (sampled at job start)
nonce_end  in  NONCE_W  last nonce of range, inclusive (sampled at job start)
target  in  DIGEST_W  hit when digest <= target, unsigned (sampled at job start)
lane_ready  in  NUM_LANES  lane i idle and able to accept a start
lane_start  out  NUM_LANES  one-cycle start pulse per lane
lane_nonce  out  NUM_LANES*NONCE_W  nonce for lane i in bits [i*NONCE_W +: NONCE_W]; held stable from start until that lane's valid
lane_valid  in  NUM_LANES  one-cycle pulse; lane_digest slice valid
lane_digest  in  NUM_LANES*DIGEST_W  digest of lane i in bits [i*DIGEST_W +: DIGEST_W]
led_processing  out  1  high while a job is in progress (states DISPATCH/WAIT/EVAL)
led_found  out  1  sticky hit indicator
found_valid  out  1  one-cycle pulse on a hit
found_nonce  out  NONCE_W  winning nonce; held until the next job start
exhausted  out  1  sticky; the range was completed without a hit

Behaviour:
- Reset: all outputs 0; state IDLE; base, done-mask and active-mask registers 0.
- Job start, IDLE with enable=1:
  - Latch nonce_start, nonce_end and target.
  - Clear led_found, exhausted and found_nonce.
  - If nonce_start > nonce_end, go to DONE and set exhausted=1 on the next cycle.
  - Otherwise load base=nonce_start and go to DISPATCH.
- Base arithmetic is NONCE_W+1 bits, so nonce_end = all-ones terminates without wrapping.
- Active mask: lane i is active when base+i <= nonce_end. Inactive lanes never get lane_start and their lane_valid is ignored.
- DISPATCH:
  - Wait until lane_ready is 1 for every active lane.
  - Then pulse lane_start for the active lanes for exactly 1 cycle, with lane_nonce[i]=base+i, and go to WAIT.
- WAIT:
  - Set done_mask[i] when lane_valid[i] is high and lane i is active.
  - Register a per-lane hit: digest_i <= target_latched.
  - When done_mask equals active_mask, go to EVAL.
  - Lanes may finish in any order and in any cycle. A lane_valid and the completion of the mask in the same cycle both count.
- EVAL (1 cycle):
  - Any hit: the lowest-index hit lane wins. found_nonce = base+idx, found_valid pulses, led_found=1, go to DONE.
  - No hit, and base+NUM_LANES > nonce_end: exhausted=1, go to DONE.
  - No hit, range remains, enable=1: base += NUM_LANES, go to DISPATCH.
  - No hit, range remains, enable=0: go to IDLE with no flags set (aborted).
- Latency: found_valid is asserted exactly 2 cycles after the cycle in which the last active lane_valid is seen (1 cycle registered compare, 1 cycle EVAL).
- DONE: holds found_nonce, led_found and exhausted. Goes to IDLE when enable=0.
- enable deasserted during DISPATCH or WAIT:
  - The in-flight round is completed and evaluated; a hit is still reported.
  - No further round starts.
  - A DISPATCH that has not yet pulsed lane_start returns to IDLE directly.
- Spurious lane_valid outside WAIT, or a second valid from a lane already done: ignored.
- Reset mid-job: immediate return to reset values. Lanes are not notified; the lane-side reset is the same net.

Decomposition:
- miner_pkg: DIGEST_W, NONCE_W default, state encoding (IDLE, DISPATCH, WAIT, EVAL, DONE) as localparams.
- Sub-module miner_hit_select: NUM_LANES-wide hit vector plus active mask in; any_hit and lowest index out. It is a pure priority encoder instantiated once.

Test Plan:
- NUM_LANES=4, start=0x10, end=0x1F, target=all-ones, lanes valid 5 cycles after start.
  - Required: found_nonce=0x10, found_valid exactly 2 cycles after the last valid, led_found=1.
- Same range; target hits only the digest for nonce 0x1A (lane 2, round 3); lanes return valid in the order 3,1,2,0.
  - Required: 3 rounds, found_nonce=0x1A, exhausted=0.
- Range 0x00..0x05, never a hit.
  - Required: round 2 starts only lanes 0-1 (nonces 0x04, 0x05); lanes 2-3 get no start; exhausted=1; led_found=0.
- Range start=0xFFFFFFFC, end=0xFFFFFFFF, no hit.
  - Required: a single round, exhausted=1, no second round, no wrap to 0.
- Drop enable during WAIT of round 1, with a hit at lane 3 of that round.
  - Required: the hit is reported; the state returns to IDLE after enable=0.
  - Repeat with no hit. Required: IDLE, flags 0, no second lane_start.
- Assert reset in WAIT with lane_valid arriving during reset.
  - Required: all outputs 0, state IDLE, a later job behaves normally.
- start=5, end=4.
  - Required: exhausted=1 one cycle after enable, lane_start never asserted.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared widths and FSM state encoding for the multi-lane miner dispatcher.
package miner_pkg;

  localparam int MINER_NONCE_W  = 32;
  localparam int MINER_DIGEST_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DISPATCH = 3'd1,
    ST_WAIT     = 3'd2,
    ST_EVAL     = 3'd3,
    ST_DONE     = 3'd4
  } miner_state_t;

endpackage

// File: rtl/miner_hit_select.sv
// Priority encoder: picks the lowest-index lane that is both active and hit.
module miner_hit_select #(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0] hit_i,
  input  logic [NUM_LANES-1:0] mask_i,
  output logic                 any_hit_o,
  output logic [IDX_W-1:0]     idx_o
);

  // Scan from the top down so the last match written is the lowest index.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    any_hit_o = 1'b0;
    idx_o     = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (hit_i[i] && mask_i[i]) begin
        any_hit_o = 1'b1;
        idx_o     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/miner_lane_dispatcher.sv
// Schedules nonce rounds across NUM_LANES hash lanes, compares returned
// digests against the latched target and reports the first winning nonce
// or exhaustion of the requested range.
module miner_lane_dispatcher
  import miner_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int NONCE_W   = MINER_NONCE_W,
  parameter int DIGEST_W  = MINER_DIGEST_W
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NONCE_W-1:0]            nonce_start,
  input  logic [NONCE_W-1:0]            nonce_end,
  input  logic [DIGEST_W-1:0]           target,
  input  logic [NUM_LANES-1:0]          lane_ready,
  output logic [NUM_LANES-1:0]          lane_start,
  output logic [NUM_LANES*NONCE_W-1:0]  lane_nonce,
  input  logic [NUM_LANES-1:0]          lane_valid,
  input  logic [NUM_LANES*DIGEST_W-1:0] lane_digest,
  output logic                          led_processing,
  output logic                          led_found,
  output logic                          found_valid,
  output logic [NONCE_W-1:0]            found_nonce,
  output logic                          exhausted
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  // One extra bit so base + NUM_LANES past an all-ones end never wraps.
  localparam logic [NONCE_W:0] LANE_STEP = (NONCE_W + 1)'(NUM_LANES);

  miner_state_t                 state_q;
  logic [NONCE_W:0]             base_q;
  logic [NONCE_W:0]             end_q;
  logic [DIGEST_W-1:0]          target_q;
  logic [NUM_LANES-1:0]         active_q;
  logic [NUM_LANES-1:0]         done_q;
  logic [NUM_LANES-1:0]         hit_q;
  logic [NUM_LANES-1:0]         lane_start_q;
  logic [NUM_LANES*NONCE_W-1:0] lane_nonce_q;
  logic                         found_valid_q;
  logic                         led_found_q;
  logic                         exhausted_q;
  logic [NONCE_W-1:0]           found_nonce_q;

  logic [NUM_LANES-1:0]         done_d;
  logic [NONCE_W:0]             base_d;
  logic                         any_hit;
  logic [IDX_W-1:0]             hit_idx;

  // Lane i takes part in a round when its nonce base+i is still inside the range.
  function automatic logic [NUM_LANES-1:0] active_of(input logic [NONCE_W:0] base,
                                                     input logic [NONCE_W:0] last);
    logic [NUM_LANES-1:0] m;
    for (int i = 0; i < NUM_LANES; i++) begin
      m[i] = (base + (NONCE_W + 1)'(i)) <= last;
    end
    return m;
  endfunction

  // Completion includes valids arriving this cycle; base of the following round.
  assign done_d = done_q | (lane_valid & active_q);
  assign base_d = base_q + LANE_STEP;

  miner_hit_select #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_hit_select (
    .hit_i     (hit_q),
    .mask_i    (active_q),
    .any_hit_o (any_hit),
    .idx_o     (hit_idx)
  );

  // Job FSM: dispatch, collect, evaluate, and hold results; all outputs registered.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      end_q         <= '0;
      target_q      <= '0;
      active_q      <= '0;
      done_q        <= '0;
      hit_q         <= '0;
      lane_start_q  <= '0;
      lane_nonce_q  <= '0;
      found_valid_q <= 1'b0;
      led_found_q   <= 1'b0;
      exhausted_q   <= 1'b0;
      found_nonce_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      lane_start_q  <= '0;
      found_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            end_q         <= {1'b0, nonce_end};
            target_q      <= target;
            led_found_q   <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
            if (nonce_start > nonce_end) begin
              exhausted_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              base_q   <= {1'b0, nonce_start};
              active_q <= active_of({1'b0, nonce_start}, {1'b0, nonce_end});
              state_q  <= ST_DISPATCH;
            end
          end
        end
        ST_DISPATCH: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if ((lane_ready & active_q) == active_q) begin
            lane_start_q <= active_q;
            for (int i = 0; i < NUM_LANES; i++) begin
              if (active_q[i]) begin
                lane_nonce_q[i*NONCE_W +: NONCE_W] <= base_q[NONCE_W-1:0] + NONCE_W'(i);
              end
            end
            done_q  <= '0;
            hit_q   <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_valid[i] && active_q[i] && !done_q[i]) begin
              hit_q[i] <= (lane_digest[i*DIGEST_W +: DIGEST_W] <= target_q);
            end
          end
          done_q <= done_d;
          if (done_d == active_q) begin
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (any_hit) begin
            found_nonce_q <= base_q[NONCE_W-1:0] + NONCE_W'(hit_idx);
            found_valid_q <= 1'b1;
            led_found_q   <= 1'b1;
            state_q       <= ST_DONE;
          end else if (base_d > end_q) begin
            exhausted_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (enable) begin
            base_q   <= base_d;
            active_q <= active_of(base_d, end_q);
            state_q  <= ST_DISPATCH;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lane_start     = lane_start_q;
  assign lane_nonce     = lane_nonce_q;
  assign led_processing = (state_q == ST_DISPATCH) || (state_q == ST_WAIT) || (state_q == ST_EVAL);
  assign led_found      = led_found_q;
  assign found_valid    = found_valid_q;
  assign found_nonce    = found_nonce_q;
  assign exhausted      = exhausted_q;

endmodule

// File: tb/tb_miner_lane_dispatcher.sv
// Self-checking bench: behavioural lanes with per-lane latency, a nonce
// scoreboard for found results and a round model for lane_start/lane_nonce.
module tb_miner_lane_dispatcher;
  import miner_pkg::*;

  localparam int NL = 4;
  localparam int NW = 32;
  localparam int DW = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [NW-1:0]     nonce_start = '0;
  logic [NW-1:0]     nonce_end = '0;
  logic [DW-1:0]     target = '0;
  logic [NL-1:0]     lane_ready = '1;
  logic [NL-1:0]     lane_start;
  logic [NL*NW-1:0]  lane_nonce;
  logic [NL-1:0]     lane_valid = '0;
  logic [NL*DW-1:0]  lane_digest = '0;
  logic              led_processing;
  logic              led_found;
  logic              found_valid;
  logic [NW-1:0]     found_nonce;
  logic              exhausted;

  always #5 clk = ~clk;

  miner_lane_dispatcher #(.NUM_LANES(NL), .NONCE_W(NW), .DIGEST_W(DW)) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .enable         (enable),
    .nonce_start    (nonce_start),
    .nonce_end      (nonce_end),
    .target         (target),
    .lane_ready     (lane_ready),
    .lane_start     (lane_start),
    .lane_nonce     (lane_nonce),
    .lane_valid     (lane_valid),
    .lane_digest    (lane_digest),
    .led_processing (led_processing),
    .led_found      (led_found),
    .found_valid    (found_valid),
    .found_nonce    (found_nonce),
    .exhausted      (exhausted)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rounds = 0;
  int found_cnt = 0;
  int last_valid_cyc = 0;
  logic [NW:0]   exp_base = '0;
  logic [NW:0]   job_end = '0;
  logic [NW-1:0] exp_q[$];

  bit            busy[NL];
  int            cnt[NL];
  logic [NW-1:0] lnonce[NL];
  int            delay[NL];

  bit            hit_en = 1'b0;
  logic [NW-1:0] hit_nonce = '0;
  logic [DW-1:0] hit_digest = '0;

  // Lane digest model: one chosen nonce gets hit_digest, all others are huge.
  function automatic logic [DW-1:0] digest_of(input logic [NW-1:0] n);
    if (hit_en && n == hit_nonce) return hit_digest;
    return {32'h8000_0000, 192'h0, n};
  endfunction

  // Reference: first nonce of the range whose digest is <= target.
  function automatic bit model_first_hit(input logic [NW-1:0] s, input logic [NW-1:0] e,
                                         input logic [DW-1:0] t, output logic [NW-1:0] n);
    n = '0;
    for (logic [NW:0] k = {1'b0, s}; k <= {1'b0, e}; k++) begin
      if (digest_of(k[NW-1:0]) <= t) begin
        n = k[NW-1:0];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock: sample DUT outputs on the falling edge, then drive the lanes.
  task automatic step();
    logic [NL-1:0] exp_mask;
    logic [NW-1:0] e;
    @(negedge clk);
    cyc++;
    if (found_valid === 1'b1) begin
      found_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL found_unexpected got=%h expected=no_found", found_nonce);
      end else begin
        e = exp_q.pop_front();
        if (found_nonce !== e) begin
          errors++;
          $display("FAIL found_nonce got=%h expected=%h", found_nonce, e);
        end
      end
      checks++;
      if (cyc - last_valid_cyc != 2) begin
        errors++;
        $display("FAIL found_latency got=%0d expected=2", cyc - last_valid_cyc);
      end
    end
    if (lane_start !== '0) begin
      rounds++;
      for (int i = 0; i < NL; i++) exp_mask[i] = (exp_base + (NW + 1)'(i)) <= job_end;
      checks++;
      if (lane_start !== exp_mask) begin
        errors++;
        $display("FAIL lane_start_mask round=%0d got=%b expected=%b", rounds, lane_start, exp_mask);
      end
      for (int i = 0; i < NL; i++) begin
        if (exp_mask[i]) begin
          checks++;
          if (lane_nonce[i*NW +: NW] !== exp_base[NW-1:0] + NW'(i)) begin
            errors++;
            $display("FAIL lane_nonce lane=%0d got=%h expected=%h", i,
                     lane_nonce[i*NW +: NW], exp_base[NW-1:0] + NW'(i));
          end
        end
      end
      exp_base = exp_base + (NW + 1)'(NL);
    end
    lane_valid = '0;
    for (int i = 0; i < NL; i++) begin
      if (busy[i]) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          lane_valid[i] = 1'b1;
          lane_digest[i*DW +: DW] = digest_of(lnonce[i]);
          busy[i] = 1'b0;
          lane_ready[i] = 1'b1;
          last_valid_cyc = cyc;
        end
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (lane_start[i] === 1'b1) begin
        busy[i] = 1'b1;
        cnt[i] = delay[i];
        lane_ready[i] = 1'b0;
        lnonce[i] = lane_nonce[i*NW +: NW];
      end
    end
  endtask

  task automatic lanes_idle();
    for (int i = 0; i < NL; i++) begin
      busy[i] = 1'b0;
      cnt[i] = 0;
      delay[i] = 5;
    end
    lane_ready = '1;
    lane_valid = '0;
    lane_digest = '0;
  endtask

  // Drive a job and push the model's expected winner (if any) to the scoreboard.
  task automatic start_job(input logic [NW-1:0] s, input logic [NW-1:0] e,
                           input logic [DW-1:0] t, input bit push_exp);
    logic [NW-1:0] n;
    nonce_start = s;
    nonce_end = e;
    target = t;
    exp_base = {1'b0, s};
    job_end = {1'b0, e};
    rounds = 0;
    found_cnt = 0;
    if (push_exp && model_first_hit(s, e, t, n)) exp_q.push_back(n);
    enable = 1'b1;
    step();
  endtask

  task automatic wait_finish(input string name, input int budget);
    int n = 0;
    while (led_found !== 1'b1 && exhausted !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout got=%0d_cycles expected=<%0d", name, n, budget);
    end
  endtask

  task automatic wait_rounds(input int r, input int budget);
    int n = 0;
    while (rounds < r && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL round_wait_timeout got=%0d expected=%0d", rounds, r);
    end
  endtask

  task automatic end_job(input string name);
    enable = 1'b0;
    step();
    step();
    checks++;
    if (dut.state_q !== ST_IDLE || led_processing !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got=%0d/%b expected=%0d/0", name, dut.state_q, led_processing, ST_IDLE);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lanes_idle();
    step();
    step();
    checks++;
    if ({lane_start, led_processing, led_found, found_valid, exhausted} !== '0) begin
      errors++;
      $display("FAIL reset_flags got=%b expected=0", {lane_start, led_processing, led_found, found_valid, exhausted});
    end
    checks++;
    if (lane_nonce !== '0 || found_nonce !== '0) begin
      errors++;
      $display("FAIL reset_nonces got=%h/%h expected=0/0", lane_nonce, found_nonce);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got=%0d expected=%0d", dut.state_q, ST_IDLE);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_first_lane_hit();
    lanes_idle();
    hit_en = 1'b0;
    start_job(32'h10, 32'h1F, '1, 1'b1);
    wait_finish("first_hit", 100);
    checks++;
    if (found_cnt != 1 || led_found !== 1'b1 || exhausted !== 1'b0 || rounds != 1) begin
      errors++;
      $display("FAIL first_hit_summary got=found%0d/led%b/exh%b/rounds%0d expected=found1/led1/exh0/rounds1",
               found_cnt, led_found, exhausted, rounds);
    end
    step();
    step();
    checks++;
    if (found_nonce !== 32'h10) begin
      errors++;
      $display("FAIL first_hit_hold got=%h expected=00000010", found_nonce);
    end
    end_job("first_hit");
  endtask

  task automatic test_out_of_order();
    lanes_idle();
    delay[0] = 5; delay[1] = 3; delay[2] = 4; delay[3] = 2;
    hit_en = 1'b1;
    hit_nonce = 32'h1A;
    hit_digest = 256'h100;
    start_job(32'h10, 32'h1F, 256'h100, 1'b1);
    wait_finish("ooo", 200);
    checks++;
    if (rounds != 3 || found_cnt != 1 || exhausted !== 1'b0 || found_nonce !== 32'h1A) begin
      errors++;
      $display("FAIL ooo_summary got=rounds%0d/found%0d/exh%b/%h expected=rounds3/found1/exh0/0000001a",
               rounds, found_cnt, exhausted, found_nonce);
    end
    end_job("ooo");
  endtask

  task automatic test_partial_round();
    lanes_idle();
    hit_en = 1'b0;
    start_job(32'h0, 32'h5, '0, 1'b1);
    wait_finish("partial", 200);
    repeat (4) step();
    checks++;
    if (rounds != 2 || exhausted !== 1'b1 || led_found !== 1'b0 || found_cnt != 0) begin
      errors++;
      $display("FAIL partial_summary got=rounds%0d/exh%b/led%b/found%0d expected=rounds2/exh1/led0/found0",
               rounds, exhausted, led_found, found_cnt);
    end
    end_job("partial");
  endtask

  task automatic test_top_of_range();
    lanes_idle();
    hit_en = 1'b0;
    start_job(32'hFFFF_FFFC, 32'hFFFF_FFFF, '0, 1'b1);
    wait_finish("top", 100);
    repeat (8) step();
    checks++;
    if (rounds != 1 || exhausted !== 1'b1 || found_cnt != 0) begin
      errors++;
      $display("FAIL top_summary got=rounds%0d/exh%b/found%0d expected=rounds1/exh1/found0",
               rounds, exhausted, found_cnt);
    end
    end_job("top");
  endtask

  task automatic test_enable_drop_hit();
    lanes_idle();
    hit_en = 1'b1;
    hit_nonce = 32'h43;
    hit_digest = 256'h80;
    start_job(32'h40, 32'h4F, 256'h100, 1'b1);
    wait_rounds(1, 50);
    enable = 1'b0;
    wait_finish("drop_hit", 50);
    repeat (3) step();
    checks++;
    if (found_cnt != 1 || rounds != 1 || led_found !== 1'b1 || found_nonce !== 32'h43) begin
      errors++;
      $display("FAIL drop_hit_summary got=found%0d/rounds%0d/led%b/%h expected=found1/rounds1/led1/00000043",
               found_cnt, rounds, led_found, found_nonce);
    end
    end_job("drop_hit");
  endtask

  task automatic test_enable_drop_nohit();
    lanes_idle();
    hit_en = 1'b0;
    start_job(32'h40, 32'h4F, '0, 1'b1);
    wait_rounds(1, 50);
    enable = 1'b0;
    repeat (12) step();
    checks++;
    if (rounds != 1 || found_cnt != 0 || led_found !== 1'b0 || exhausted !== 1'b0) begin
      errors++;
      $display("FAIL drop_nohit_summary got=rounds%0d/found%0d/led%b/exh%b expected=rounds1/found0/led0/exh0",
               rounds, found_cnt, led_found, exhausted);
    end
    end_job("drop_nohit");
  endtask

  task automatic test_reset_in_wait();
    lanes_idle();
    hit_en = 1'b0;
    start_job(32'h10, 32'h1F, '0, 1'b1);
    wait_rounds(1, 50);
    step();
    step();
    reset = 1'b1;
    enable = 1'b0;
    lane_valid = '1;
    lane_digest = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({lane_start, led_processing, led_found, found_valid, exhausted} !== '0 ||
        lane_nonce !== '0 || found_nonce !== '0) begin
      errors++;
      $display("FAIL reset_wait_outputs got=%b/%h/%h expected=0/0/0",
               {lane_start, led_processing, led_found, found_valid, exhausted}, lane_nonce, found_nonce);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_wait_state got=%0d expected=%0d", dut.state_q, ST_IDLE);
    end
    reset = 1'b0;
    lanes_idle();
    repeat (4) step();
    checks++;
    if (rounds != 1 || found_cnt != 0 || led_processing !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_quiet got=rounds%0d/found%0d/proc%b expected=rounds1/found0/proc0",
               rounds, found_cnt, led_processing);
    end
    test_first_lane_hit();
  endtask

  task automatic test_empty_range();
    lanes_idle();
    hit_en = 1'b0;
    start_job(32'h5, 32'h4, '1, 1'b1);
    checks++;
    if (exhausted !== 1'b1 || led_processing !== 1'b0 || led_found !== 1'b0) begin
      errors++;
      $display("FAIL empty_flags got=exh%b/proc%b/led%b expected=exh1/proc0/led0",
               exhausted, led_processing, led_found);
    end
    repeat (5) step();
    checks++;
    if (rounds != 0 || found_cnt != 0) begin
      errors++;
      $display("FAIL empty_no_start got=rounds%0d/found%0d expected=rounds0/found0", rounds, found_cnt);
    end
    end_job("empty");
    checks++;
    if (exhausted !== 1'b1) begin
      errors++;
      $display("FAIL empty_sticky got=%b expected=1", exhausted);
    end
  endtask

  initial begin
    test_reset();
    test_first_lane_hit();
    test_out_of_order();
    test_partial_round();
    test_top_of_range();
    test_enable_drop_hit();
    test_enable_drop_nohit();
    test_reset_in_wait();
    test_empty_range();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
